// File: rtl/pilha_pkg.sv
// Shared definitions for the stack sequencer: sizes, opcodes, state encoding,
// error codes and the operand-count helper.
package pilha_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_RES_W  = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_TOS_W  = 16;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PUSH  = 3'd1,
    S_POP_B = 3'd2,
    S_CAP_B = 3'd3,
    S_POP_A = 3'd4,
    S_CAP_A = 3'd5,
    S_WB    = 3'd6,
    S_RESP  = 3'd7
  } state_e;

  function automatic logic [1:0] operands_needed(input logic [3:0] op);
    logic [1:0] n;
    case (op)
      OP_POP, OP_NOT:                                  n = 2'd1;
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR:   n = 2'd2;
      default:                                         n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Sequences stack-machine commands: pops operands from the stack, drives the ALU,
// pushes the result back and reports done/result/error to the control unit.
module stack_sequencer
  import pilha_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RES_W  = DEF_RES_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TOS_W  = DEF_TOS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              stk_push,
  output logic              stk_pop,
  output logic              stk_sel,
  output logic [DATA_W-1:0] stk_din_uc,
  input  logic [DATA_W-1:0] stk_dout,
  input  logic [TOS_W-1:0]  stk_tos,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_res
);

  state_e            state_q, state_d;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] imm_q, opa_q, opb_q, res_q;
  logic [1:0]        err_code_q, chk_err_s;
  logic              carry_q;
  logic              accept_s;

  assign accept_s = cmd_valid && (state_q == S_IDLE);

  // Admission check of the incoming command against the current occupancy.
  always_comb begin
    chk_err_s = ERR_NONE;
    if (cmd_op > OP_NOT) begin
      chk_err_s = ERR_ILLEGAL;
    end else if ((cmd_op == OP_PUSH) && (stk_tos >= TOS_W'(DEPTH))) begin
      chk_err_s = ERR_OVERFLOW;
    end else if (stk_tos < TOS_W'(operands_needed(cmd_op))) begin
      chk_err_s = ERR_UNDERFLOW;
    end else begin
      chk_err_s = ERR_NONE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!accept_s) begin
          state_d = S_IDLE;
        end else if ((chk_err_s != ERR_NONE) || (cmd_op == OP_NOP)) begin
          state_d = S_RESP;
        end else if (cmd_op == OP_PUSH) begin
          state_d = S_PUSH;
        end else begin
          state_d = S_POP_B;
        end
      end
      S_PUSH:  state_d = S_RESP;
      S_POP_B: state_d = S_CAP_B;
      S_CAP_B: begin
        if (op_q == OP_POP) begin
          state_d = S_RESP;
        end else if (op_q == OP_NOT) begin
          state_d = S_WB;
        end else begin
          state_d = S_POP_A;
        end
      end
      S_POP_A: state_d = S_CAP_A;
      S_CAP_A: state_d = S_WB;
      S_WB:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command, operand and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= 4'd0;
      imm_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            op_q       <= cmd_op;
            imm_q      <= cmd_imm;
            opa_q      <= '0;
            opb_q      <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            err_code_q <= chk_err_s;
          end
        end
        S_CAP_B: begin
          opb_q <= stk_dout;
          if (op_q == OP_POP) begin
            res_q <= stk_dout;
          end
        end
        S_CAP_A: opa_q <= stk_dout;
        S_WB: begin
          res_q   <= alu_res[DATA_W-1:0];
          carry_q <= |alu_res[RES_W-1:DATA_W];
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode; response fields are exposed only while done is high.
  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    done       = 1'b0;
    err        = 1'b0;
    err_code   = ERR_NONE;
    result     = '0;
    carry      = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_sel    = 1'b0;
    stk_din_uc = '0;
    alu_op     = 4'd0;
    alu_a      = '0;
    alu_b      = '0;
    if (state_q != S_IDLE) begin
      alu_op = op_q;
      alu_a  = opa_q;
      alu_b  = opb_q;
    end else begin
      alu_op = 4'd0;
    end
    case (state_q)
      S_PUSH: begin
        stk_push   = 1'b1;
        stk_din_uc = imm_q;
      end
      S_POP_B, S_POP_A: stk_pop = 1'b1;
      S_WB: begin
        stk_push = 1'b1;
        stk_sel  = 1'b1;
      end
      S_RESP: begin
        done     = 1'b1;
        err      = (err_code_q != ERR_NONE);
        err_code = err_code_q;
        result   = res_q;
        carry    = carry_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: behavioural stack and ALU around the DUT, plus a
// queue-based reference of expected stack contents and command responses.
module tb_stack_sequencer;
  import pilha_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_imm;
  logic        done, err, carry;
  logic [1:0]  err_code;
  logic [15:0] result;
  logic        stk_push, stk_pop, stk_sel;
  logic [15:0] stk_din_uc, stk_dout, stk_tos;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [31:0] alu_res;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .done(done), .err(err), .err_code(err_code),
    .result(result), .carry(carry), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_sel(stk_sel), .stk_din_uc(stk_din_uc), .stk_dout(stk_dout), .stk_tos(stk_tos),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] xa, xb;
    xa = {16'h0, a};
    xb = {16'h0, b};
    case (op)
      4'd3:    return xa + xb;
      4'd4:    return xa - xb;
      4'd5:    return xa * xb;
      4'd6:    return xa & xb;
      4'd7:    return xa | xb;
      4'd8:    return xa ^ xb;
      4'd9:    return {16'h0, ~b};
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural 16-deep stack and combinational ALU.
  logic [15:0] env_mem [16];
  int          env_tos  = 0;
  logic [15:0] env_dout = 16'h0;
  assign stk_tos  = 16'(env_tos);
  assign stk_dout = env_dout;
  assign alu_res  = alu_f(alu_op, alu_a, alu_b);

  always @(posedge clk) begin
    if (stk_push && env_tos < 16) begin
      env_mem[env_tos] <= stk_sel ? alu_res[15:0] : stk_din_uc;
      env_tos <= env_tos + 1;
    end else if (stk_pop && env_tos > 0) begin
      env_dout <= env_mem[env_tos-1];
      env_tos  <= env_tos - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          n_push = 0, n_pop = 0;
  logic [15:0] wb_a = 16'h0, wb_b = 16'h0;
  logic [3:0]  wb_op = 4'h0;

  // Per-cycle monitor: strobe exclusivity, quiet response outputs, WB snapshot.
  always @(negedge clk) begin
    check("push_pop_excl", 64'(stk_push & stk_pop), 64'h0);
    if (!done) check("quiet_resp", {err, err_code, result, carry}, 64'h0);
    if (stk_push) n_push <= n_push + 1;
    if (stk_pop)  n_pop  <= n_pop + 1;
    if (stk_push && stk_sel) begin
      wb_a  <= alu_a;
      wb_b  <= alu_b;
      wb_op <= alu_op;
    end
  end

  logic [15:0] ref_q [$];
  logic [15:0] last_result;
  logic        last_carry;
  logic [1:0]  last_code;

  task automatic model(input logic [3:0] op, input logic [15:0] imm,
                       output logic [1:0] ecode, output logic [15:0] eres,
                       output logic ecarry, output int elat, output int epush,
                       output int epop);
    logic [15:0] a, b;
    logic [31:0] r;
    ecode = 2'b00; eres = 16'h0; ecarry = 1'b0; elat = 1; epush = 0; epop = 0;
    if (op > 4'd9) ecode = 2'b11;
    else if (op == 4'd0) elat = 1;
    else if (op == 4'd1) begin
      if (ref_q.size() >= 16) ecode = 2'b10;
      else begin ref_q.push_back(imm); elat = 2; epush = 1; end
    end else if (op == 4'd2 || op == 4'd9) begin
      if (ref_q.size() < 1) ecode = 2'b01;
      else begin
        b = ref_q.pop_back();
        epop = 1;
        if (op == 4'd2) begin eres = b; elat = 3; end
        else begin
          r = alu_f(op, 16'h0, b);
          eres = r[15:0]; ecarry = |r[31:16];
          ref_q.push_back(eres); elat = 4; epush = 1;
        end
      end
    end else begin
      if (ref_q.size() < 2) ecode = 2'b01;
      else begin
        b = ref_q.pop_back();
        a = ref_q.pop_back();
        r = alu_f(op, a, b);
        eres = r[15:0]; ecarry = |r[31:16];
        ref_q.push_back(eres); elat = 6; epush = 1; epop = 2;
      end
    end
  endtask

  // Issues one command from a negedge, waits for done and checks everything.
  task automatic run_cmd(input logic [3:0] op, input logic [15:0] imm, input string tag);
    logic [1:0]  ecode;
    logic [15:0] eres;
    logic        ecarry;
    int elat, epush, epop, lat, p0, q0, k;
    model(op, imm, ecode, eres, ecarry, elat, epush, epop);
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    check({tag, "_ready"}, 64'(cmd_ready), 64'h1);
    p0 = n_push; q0 = n_pop;
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_imm = 16'($urandom);
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        last_result = result; last_carry = carry; last_code = err_code;
        check({tag, "_err"}, {err, err_code}, {(ecode != 2'b00), ecode});
        check({tag, "_result"}, {result, carry}, {eres, ecarry});
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_strobes"}, {32'(n_push - p0), 32'(n_pop - q0)}, {32'(epush), 32'(epop)});
    check({tag, "_tos"}, 64'(env_tos), 64'(ref_q.size()));
    if (ref_q.size() > 0) check({tag, "_top"}, 64'(env_mem[env_tos-1]), 64'(ref_q[$]));
  endtask

  task automatic chk_rst_outputs(input string tag);
    check({tag, "_ready"}, 64'(cmd_ready), 64'h1);
    check({tag, "_resp"}, {done, err, err_code, result, carry, stk_push, stk_pop, stk_sel},
          64'h0);
    check({tag, "_data"}, {stk_din_uc, alu_op, alu_a, alu_b}, 64'h0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_imm = 16'h0;
    last_result = 16'h0; last_carry = 1'b0; last_code = 2'b00;
    repeat (3) @(negedge clk);
    chk_rst_outputs("reset_init");
    rst = 1'b1;
    @(negedge clk);

    // 1: reset mid-PUSH abandons the command; first command after release is taken.
    cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_imm = 16'h1234;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("push_strobe_seen", 64'(stk_push), 64'h1);
    rst = 1'b0;
    #1 chk_rst_outputs("reset_mid");
    repeat (3) begin
      @(negedge clk);
      check("reset_no_done", 64'(done), 64'h0);
    end
    rst = 1'b1;
    run_cmd(OP_NOP, 16'h0, "nop_after_rst");
    check("tos_after_abandon", 64'(env_tos), 64'h0);

    // 2: PUSH 5, PUSH 3, ADD.
    run_cmd(OP_PUSH, 16'd5, "push5");
    run_cmd(OP_PUSH, 16'd3, "push3");
    run_cmd(OP_ADD, 16'h0, "add");
    check("wb_operands", {wb_op, wb_a, wb_b}, {4'd3, 16'd5, 16'd3});
    check("add_result", {last_result, last_carry}, {16'h0008, 1'b0});

    // 3: MUL carry and SUB wraparound.
    run_cmd(OP_PUSH, 16'h0100, "push100a");
    run_cmd(OP_PUSH, 16'h0100, "push100b");
    run_cmd(OP_MUL, 16'h0, "mul");
    check("mul_fixed", {last_result, last_carry}, {16'h0000, 1'b1});
    run_cmd(OP_PUSH, 16'd3, "push_a3");
    run_cmd(OP_PUSH, 16'd5, "push_b5");
    run_cmd(OP_SUB, 16'h0, "sub");
    check("sub_fixed", 64'(last_result), 64'hFFFE);

    // 4: underflow cases.
    while (ref_q.size() > 0) run_cmd(OP_POP, 16'h0, "drain");
    run_cmd(OP_PUSH, 16'h00AA, "push_one");
    run_cmd(OP_ADD, 16'h0, "add_underflow");
    check("add_uf_code", 64'(last_code), 64'h1);
    run_cmd(OP_POP, 16'h0, "pop_one");
    run_cmd(OP_POP, 16'h0, "pop_underflow");
    check("pop_uf_code", 64'(last_code), 64'h1);

    // 5: overflow, illegal opcode, NOP.
    for (int i = 0; i < 16; i++) run_cmd(OP_PUSH, 16'($urandom), "fill");
    run_cmd(OP_PUSH, 16'd7, "push_overflow");
    check("push_of_code", 64'(last_code), 64'h2);
    run_cmd(4'd15, 16'h0, "illegal");
    check("illegal_code", 64'(last_code), 64'h3);
    run_cmd(OP_NOP, 16'h0, "nop");

    // 6: reset during CAP_A of an XOR.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_imm = 16'h0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    void'(ref_q.pop_back());
    void'(ref_q.pop_back());
    #1 chk_rst_outputs("reset_cap_a");
    repeat (3) begin
      @(negedge clk);
      check("reset_xor_no_done", 64'(done), 64'h0);
    end
    check("tos_after_xor_abort", 64'(env_tos), 64'(ref_q.size()));
    rst = 1'b1;
    run_cmd(OP_PUSH, 16'd9, "push9");
    run_cmd(OP_POP, 16'h0, "pop9");
    check("pop9_fixed", 64'(last_result), 64'h9);

    // Randomized command stream against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 15));
      if (ref_q.size() < 3 && $urandom_range(0, 1) == 1) rop = OP_PUSH;
      run_cmd(rop, 16'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
